// File: rtl/key_command_encoder_pkg.sv
// Shared types and helpers for key_command_encoder.
// Go codes are shared with the game core, gameBoardPart2 and movementCounter.
package key_command_encoder_pkg;

  localparam logic [2:0] GO_NONE  = 3'b000;
  localparam logic [2:0] GO_UP    = 3'b001;
  localparam logic [2:0] GO_DOWN  = 3'b010;
  localparam logic [2:0] GO_LEFT  = 3'b011;
  localparam logic [2:0] GO_RIGHT = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_FIRE     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_REL_DB   = 3'd4
  } kce_state_t;

  // Fixed priority among simultaneously pressed keys: [3] > [2] > [1] > [0].
  function automatic logic [1:0] prio_idx(input logic [3:0] ks_n);
    if (!ks_n[3])      return 2'd3;
    else if (!ks_n[2]) return 2'd2;
    else if (!ks_n[1]) return 2'd1;
    else               return 2'd0;
  endfunction

  // Key index to go code: 3=up, 2=down, 1=left, 0=right.
  function automatic logic [2:0] go_code(input logic [1:0] idx);
    case (idx)
      2'd3:    return GO_UP;
      2'd2:    return GO_DOWN;
      2'd1:    return GO_LEFT;
      default: return GO_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/key_command_encoder_key_sync.sv
// key_sync: 4-bit two-flop synchroniser for the raw active-low buttons.
// Resets to all-ones so every key reads as released out of reset.
module key_sync (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two-stage capture of the asynchronous key pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_command_encoder.sv
// key_command_encoder: synchronises, debounces and priority-encodes the four
// active-low KEY buttons into single-cycle go commands.
// Optional feature macro: KEY_COMMAND_ENCODER_AUTO_REPEAT_EN (auto-repeat while held).
module key_command_encoder
  import key_command_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic       enable,
  output logic [2:0] go,
  output logic       key_held
);

  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CYC = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    w_ks_n;
  kce_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_key_idx, w_key_idx_nxt;
  logic [2:0]    r_go, w_go_nxt;
  logic          r_key_held, w_held_nxt;
  logic          w_any_low, w_all_high, w_latched_low;
  logic          w_rep_fire;

  key_sync u_key_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (key_n),
    .o_q    (w_ks_n)
  );

  assign w_any_low     = ~&w_ks_n;
  assign w_all_high    = &w_ks_n;
  assign w_latched_low = ~w_ks_n[r_key_idx];

  // State, counter, latched key and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_key_idx  <= '0;
      r_go       <= GO_NONE;
      r_key_held <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_key_idx  <= w_key_idx_nxt;
      r_go       <= w_go_nxt;
      r_key_held <= w_held_nxt;
    end
  end

  // Next-state logic with the debounce counter cleared on every state entry.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_key_idx_nxt = r_key_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_any_low) begin
          w_key_idx_nxt = prio_idx(w_ks_n);
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (w_latched_low) begin
          if (r_cnt == DB_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_FIRE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FIRE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_all_high) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REL_DB;
        end
      end
      ST_REL_DB: begin
        if (w_all_high) begin
          if (r_cnt == DB_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef KEY_COMMAND_ENCODER_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] r_rcnt, w_rcnt_nxt;
  logic          r_rep_phase, w_rep_phase_nxt;

  // Repeat counter and phase (first delay vs. steady period).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rcnt      <= '0;
      r_rep_phase <= 1'b0;
    end else begin
      r_rcnt      <= w_rcnt_nxt;
      r_rep_phase <= w_rep_phase_nxt;
    end
  end

  // Runs only while staying in HOLD with the latched key down; anything else restarts it.
  always_comb begin
    w_rcnt_nxt      = r_rcnt;
    w_rep_phase_nxt = r_rep_phase;
    w_rep_fire      = 1'b0;
    if (r_state == ST_HOLD && w_state_nxt == ST_HOLD && w_latched_low) begin
      if (r_rcnt == (r_rep_phase ? RP_LAST : RD_LAST)) begin
        w_rep_fire      = 1'b1;
        w_rcnt_nxt      = '0;
        w_rep_phase_nxt = 1'b1;
      end else begin
        w_rcnt_nxt = r_rcnt + 1'b1;
      end
    end else begin
      w_rcnt_nxt      = '0;
      w_rep_phase_nxt = 1'b0;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Output decode from the next state so go and key_held line up with the state register.
  always_comb begin
    w_go_nxt   = GO_NONE;
    w_held_nxt = 1'b0;
    if (enable && (w_state_nxt == ST_FIRE || w_rep_fire))
      w_go_nxt = go_code(r_key_idx);
    if (w_state_nxt == ST_FIRE || w_state_nxt == ST_HOLD || w_state_nxt == ST_REL_DB)
      w_held_nxt = 1'b1;
  end

  assign go       = r_go;
  assign key_held = r_key_held;

endmodule
